// File: rtl/pull_down_scan_scheduler_pkg.sv
// Shared state encoding and constant-width helpers for the pull-down scan scheduler.
// No latency and no handshake here: types and pure functions only.
package pull_down_scan_scheduler_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      DISCHARGE = 2'd1,
      SETTLE    = 2'd2,
      SAMPLE    = 2'd3
   } state_t;

   function automatic int clog2_int(input int value);
      int result;
      int rem;
      result = 0;
      rem    = value - 1;
      while (rem > 0) begin
         result = result + 1;
         rem    = rem >> 1;
      end
      return result;
   endfunction

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/pull_down_scan_scheduler_if.sv
// Pad-side and user-side signals of the scan scheduler; no latency of its own.
// There is no backpressure: sample_valid and scan_done are fire-and-forget pulses.
interface pull_down_scan_scheduler_if #(
   parameter int NUM_BANKS = 4,
   parameter int WIDTH     = 8
);
   logic                       enable;
   logic [NUM_BANKS-1:0]       bank_mask;
   logic [NUM_BANKS*WIDTH-1:0] pad_in;
   logic [NUM_BANKS-1:0]       pad_pull_low;
   logic [NUM_BANKS*WIDTH-1:0] sample_data;
   logic [NUM_BANKS-1:0]       sample_valid;
   logic                       scan_done;
   logic                       busy;

   modport master (
      output enable, bank_mask, pad_in,
      input  pad_pull_low, sample_data, sample_valid, scan_done, busy
   );

   modport slave (
      input  enable, bank_mask, pad_in,
      output pad_pull_low, sample_data, sample_valid, scan_done, busy
   );
endinterface

// File: rtl/pull_down_scan_scheduler_sync_2ff.sv
// Two-flop synchroniser for asynchronous pad inputs, 2-cycle latency, reset to 0.
// No backpressure: samples every clock.
module sync_2ff #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] data_async,
   output logic [WIDTH-1:0] data_sync
);
   logic [WIDTH-1:0] meta;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta      <= '0;
         data_sync <= '0;
      end else begin
         meta      <= data_async;
         data_sync <= meta;
      end
   end
endmodule

// File: rtl/pull_down_scan_scheduler.sv
// Round-robin emulated pull-down: per bank discharge, release, settle, capture (D+S+1 cycles).
// No backpressure: results are single-cycle pulses; enable only stops the scan at a bank boundary.
module pull_down_scan_scheduler
   import pull_down_scan_scheduler_pkg::*;
#(
   parameter int NUM_BANKS        = 4,
   parameter int WIDTH            = 8,
   parameter int DISCHARGE_CYCLES = 3,
   parameter int SETTLE_CYCLES    = 2
) (
   input logic                       clk,
   input logic                       rst,
   pull_down_scan_scheduler_if.slave bus
);
   localparam int BANK_W = (NUM_BANKS > 1) ? clog2_int(NUM_BANKS) : 1;
   localparam int CNT_W  = clog2_int(max_int(DISCHARGE_CYCLES, SETTLE_CYCLES) + 1);
   localparam logic [CNT_W-1:0] DIS_LAST = CNT_W'(DISCHARGE_CYCLES - 1);
   localparam logic [CNT_W-1:0] SET_LAST = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   state_t                     state, state_nxt;
   logic [CNT_W-1:0]           cnt, cnt_nxt;
   logic [BANK_W-1:0]          cur, cur_nxt;
   logic [NUM_BANKS*WIDTH-1:0] pad_sync;
   logic [NUM_BANKS-1:0]       cur_onehot;
   logic [NUM_BANKS-1:0]       pull;
   logic [BANK_W:0]            first_sel, step_sel;
   logic                       mask_any;
   logic                       capture;
   logic                       wrap;

   sync_2ff #(.WIDTH(NUM_BANKS*WIDTH)) u_pad_sync (
      .clk        (clk),
      .rst        (rst),
      .data_async (bus.pad_in),
      .data_sync  (pad_sync)
   );

   // Returns {wrap, index}: the lowest set bit above 'from' (any bit when !use_from),
   // otherwise wrap=1 with the lowest set bit overall.
   function automatic logic [BANK_W:0] next_bank(input logic [NUM_BANKS-1:0] mask,
                                                 input logic [BANK_W-1:0]    from,
                                                 input logic                 use_from);
      logic [BANK_W-1:0] low;
      logic [BANK_W-1:0] above;
      logic              found_above;
      low         = '0;
      above       = '0;
      found_above = 1'b0;
      for (int i = NUM_BANKS - 1; i >= 0; i--) begin
         if (mask[i]) begin
            low = BANK_W'(i);
            if (!use_from || (i > int'(from))) begin
               above       = BANK_W'(i);
               found_above = 1'b1;
            end
         end
      end
      return found_above ? {1'b0, above} : {1'b1, low};
   endfunction

   assign cur_onehot = NUM_BANKS'(1) << cur;
   assign mask_any   = |bus.bank_mask;
   assign first_sel  = next_bank(bus.bank_mask, cur, 1'b0);
   assign step_sel   = next_bank(bus.bank_mask, cur, 1'b1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
         cur   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         cur   <= cur_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt + CNT_ONE;
      cur_nxt   = cur;
      pull      = '0;
      capture   = 1'b0;
      wrap      = 1'b0;
      case (state)
         IDLE: begin
            cnt_nxt = '0;
            if (bus.enable && mask_any) begin
               state_nxt = DISCHARGE;
               cur_nxt   = first_sel[BANK_W-1:0];
            end
         end
         DISCHARGE: begin
            pull = cur_onehot;
            if (cnt == DIS_LAST) begin
               state_nxt = SETTLE;
               cnt_nxt   = '0;
            end
         end
         SETTLE: begin
            if (cnt == SET_LAST) begin
               state_nxt = SAMPLE;
               cnt_nxt   = '0;
            end
         end
         SAMPLE: begin
            capture = 1'b1;
            wrap    = step_sel[BANK_W];
            cnt_nxt = '0;
            // The mask is only looked at here and in IDLE, so mid-bank edits never truncate a bank.
            if (bus.enable && mask_any) begin
               state_nxt = DISCHARGE;
               cur_nxt   = step_sel[BANK_W-1:0];
            end else begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.sample_data  <= '0;
         bus.sample_valid <= '0;
         bus.scan_done    <= 1'b0;
      end else begin
         bus.sample_valid <= capture ? cur_onehot : '0;
         bus.scan_done    <= capture & wrap;
         if (capture) begin
            bus.sample_data[cur*WIDTH +: WIDTH] <= pad_sync[cur*WIDTH +: WIDTH];
         end
      end
   end

   // Decoded straight from the async-reset state register so reset releases the pads at once.
   assign bus.pad_pull_low = pull;
   assign bus.busy         = (state != IDLE);
endmodule

// File: tb/tb_pull_down_scan_scheduler.sv
// Directed bench for pull_down_scan_scheduler with a pad model that reads 0 while pulled low.
module tb_pull_down_scan_scheduler;
   logic clk = 1'b0;
   logic rst;
   logic [7:0] pad_val [4];
   int   checks = 0;
   int   errors = 0;
   int   ph, s, bk, pb;
   logic [3:0] epl, esv;
   logic esd;

   pull_down_scan_scheduler_if #(.NUM_BANKS(4), .WIDTH(8)) bus ();

   pull_down_scan_scheduler #(
      .NUM_BANKS(4), .WIDTH(8), .DISCHARGE_CYCLES(3), .SETTLE_CYCLES(2)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   always_comb begin
      bus.pad_in = '0;
      for (int b = 0; b < 4; b++) begin
         bus.pad_in[b*8 +: 8] = bus.pad_pull_low[b] ? 8'h00 : pad_val[b];
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input string tag, input logic [3:0] pl, input logic [3:0] sv,
                      input logic sd, input logic bz);
      check({tag, "_pull"},  32'(bus.pad_pull_low), 32'(pl));
      check({tag, "_valid"}, 32'(bus.sample_valid), 32'(sv));
      check({tag, "_done"},  32'(bus.scan_done),    32'(sd));
      check({tag, "_busy"},  32'(bus.busy),         32'(bz));
   endtask

   task automatic wait_idle(input string tag);
      for (int i = 0; i < 20; i++) begin
         if (!bus.busy) break;
         @(negedge clk);
      end
      check({tag, "_idle"}, 32'(bus.busy), 32'd0);
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      rst           = 1'b1;
      bus.enable    = 1'b0;
      bus.bank_mask = 4'b0000;
      pad_val[0] = 8'hFF; pad_val[1] = 8'h5A; pad_val[2] = 8'h3C; pad_val[3] = 8'hC3;

      @(negedge clk);
      cyc("reset", 4'b0000, 4'b0000, 1'b0, 1'b0);
      check("reset_data", bus.sample_data, 32'h0);
      rst = 1'b0;

      // Single bank 0: 3 low, 3 released, pulse every 6 cycles.
      @(negedge clk);
      bus.enable = 1'b1; bus.bank_mask = 4'b0001;
      for (int c = 1; c <= 13; c++) begin
         @(negedge clk);
         ph  = (c - 1) % 6;
         epl = (ph < 3) ? 4'b0001 : 4'b0000;
         esv = (c > 1 && ph == 0) ? 4'b0001 : 4'b0000;
         esd = (c > 1 && ph == 0);
         cyc($sformatf("t1c%0d", c), epl, esv, esd, 1'b1);
         if (c == 7) check("t1_data", bus.sample_data, 32'h0000_00FF);
      end
      bus.enable = 1'b0;
      wait_idle("t1");

      // Banks 1 and 3 alternate, scan_done with bank 3.
      bus.enable = 1'b1; bus.bank_mask = 4'b1010;
      for (int c = 1; c <= 25; c++) begin
         @(negedge clk);
         s   = (c - 1) / 6;
         ph  = (c - 1) % 6;
         bk  = (s % 2 == 0) ? 1 : 3;
         pb  = (s % 2 == 0) ? 3 : 1;
         epl = (ph < 3) ? 4'(1 << bk) : 4'b0000;
         esv = (c > 1 && ph == 0) ? 4'(1 << pb) : 4'b0000;
         esd = (c > 1 && ph == 0 && pb == 3);
         cyc($sformatf("t2c%0d", c), epl, esv, esd, 1'b1);
         if (c == 13) check("t2_data", bus.sample_data, 32'hC300_5AFF);
      end

      // Switch to bank 2 alone, then drop enable inside its discharge.
      bus.bank_mask = 4'b0100; pad_val[1] = 8'h77;
      @(negedge clk); cyc("t3c26", 4'b0010, 4'b0000, 1'b0, 1'b1);
      @(negedge clk); cyc("t3c27", 4'b0010, 4'b0000, 1'b0, 1'b1);
      @(negedge clk); cyc("t3c28", 4'b0000, 4'b0000, 1'b0, 1'b1);
      @(negedge clk); cyc("t3c29", 4'b0000, 4'b0000, 1'b0, 1'b1);
      @(negedge clk); cyc("t3c30", 4'b0000, 4'b0000, 1'b0, 1'b1);
      @(negedge clk); cyc("t3c31", 4'b0100, 4'b0010, 1'b0, 1'b1);
      check("t3_data1", bus.sample_data, 32'hC300_77FF);
      @(negedge clk); cyc("t3c32", 4'b0100, 4'b0000, 1'b0, 1'b1);
      bus.enable = 1'b0;
      @(negedge clk); cyc("t3c33", 4'b0100, 4'b0000, 1'b0, 1'b1);
      @(negedge clk); cyc("t3c34", 4'b0000, 4'b0000, 1'b0, 1'b1);
      @(negedge clk); cyc("t3c35", 4'b0000, 4'b0000, 1'b0, 1'b1);
      @(negedge clk); cyc("t3c36", 4'b0000, 4'b0000, 1'b0, 1'b1);
      @(negedge clk); cyc("t3c37", 4'b0000, 4'b0100, 1'b1, 1'b0);
      check("t3_data2", bus.sample_data, 32'hC33C_77FF);
      @(negedge clk); cyc("t3c38", 4'b0000, 4'b0000, 1'b0, 1'b0);

      // Mask 0011 -> 0100 during bank 0 settle.
      pad_val[0] = 8'h96; pad_val[2] = 8'h69;
      bus.enable = 1'b1; bus.bank_mask = 4'b0011;
      for (int c = 1; c <= 3; c++) begin
         @(negedge clk); cyc($sformatf("t4c%0d", c), 4'b0001, 4'b0000, 1'b0, 1'b1);
      end
      @(negedge clk); cyc("t4c4", 4'b0000, 4'b0000, 1'b0, 1'b1);
      bus.bank_mask = 4'b0100;
      @(negedge clk); cyc("t4c5", 4'b0000, 4'b0000, 1'b0, 1'b1);
      @(negedge clk); cyc("t4c6", 4'b0000, 4'b0000, 1'b0, 1'b1);
      @(negedge clk); cyc("t4c7", 4'b0100, 4'b0001, 1'b0, 1'b1);
      check("t4_data0", bus.sample_data, 32'hC33C_7796);
      for (int c = 8; c <= 12; c++) begin
         @(negedge clk);
         cyc($sformatf("t4c%0d", c), (c < 10) ? 4'b0100 : 4'b0000, 4'b0000, 1'b0, 1'b1);
      end
      @(negedge clk); cyc("t4c13", 4'b0100, 4'b0100, 1'b1, 1'b1);
      check("t4_data2", bus.sample_data, 32'hC369_7796);
      bus.enable = 1'b0;
      wait_idle("t4");

      // Asynchronous reset in the middle of a discharge.
      bus.enable = 1'b1; bus.bank_mask = 4'b0001;
      @(negedge clk); cyc("t5c1", 4'b0001, 4'b0000, 1'b0, 1'b1);
      @(negedge clk); cyc("t5c2", 4'b0001, 4'b0000, 1'b0, 1'b1);
      #2 rst = 1'b1;
      #1 cyc("t5rst", 4'b0000, 4'b0000, 1'b0, 1'b0);
      check("t5rst_data", bus.sample_data, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      for (int c = 1; c <= 6; c++) begin
         @(negedge clk);
         cyc($sformatf("t5f%0d", c), (c < 4) ? 4'b0001 : 4'b0000, 4'b0000, 1'b0, 1'b1);
      end
      @(negedge clk); cyc("t5f7", 4'b0001, 4'b0001, 1'b1, 1'b1);
      check("t5_data", bus.sample_data, 32'h0000_0096);
      bus.enable = 1'b0;
      wait_idle("t5");

      // Enabled with an empty mask, then bank 3 appears.
      bus.enable = 1'b1; bus.bank_mask = 4'b0000;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk); cyc($sformatf("t6z%0d", c), 4'b0000, 4'b0000, 1'b0, 1'b0);
      end
      bus.bank_mask = 4'b1000;
      for (int c = 1; c <= 6; c++) begin
         @(negedge clk);
         cyc($sformatf("t6c%0d", c), (c < 4) ? 4'b1000 : 4'b0000, 4'b0000, 1'b0, 1'b1);
      end
      @(negedge clk); cyc("t6c7", 4'b1000, 4'b1000, 1'b1, 1'b1);
      check("t6_data", bus.sample_data, 32'hC300_0096);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
